// File: rtl/pong_pio_edge_in_pkg.sv
// Shared constants for the Pong PIO edge-capture peripheral.
// Register word addresses and the edge-detect mode encodings.
package pong_pio_pkg;

    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pong_pio_edge_in_if.sv
// Avalon-MM slave bus bundle for the Pong PIO edge-capture peripheral.
interface pong_pio_edge_in_if;
    import pong_pio_pkg::*;

    logic [1:0]           address;
    logic                 write;
    logic [BUS_WIDTH-1:0] writedata;
    logic [BUS_WIDTH-1:0] readdata;

    modport master (output address, write, writedata, input readdata);
    modport slave  (input address, write, writedata, output readdata);

endinterface

// File: rtl/pong_pio_edge_in_sync.sv
// Multi-flop synchronizer bringing asynchronous paddle/button inputs into clk.
module pong_pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // NOTE: every stage is reset so no stale input level survives into the
    // edge detector after reset; a plain flop chain, not a RAM, so this is cheap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/pong_pio_edge_in.sv
// Edge-capturing parallel input port: synchronize, detect edges, latch them
// into a write-1-to-clear capture register and raise a masked level interrupt.
module pong_pio_edge_in
    import pong_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset,
    pong_pio_edge_in_if.slave     bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] w_sync_q;
    logic [DATA_WIDTH-1:0] r_prev_q;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_clear;
    logic [DATA_WIDTH-1:0] r_edge_capture;
    logic [DATA_WIDTH-1:0] r_irq_mask;
    logic [BUS_WIDTH-1:0]  w_rd_nxt;
    logic [BUS_WIDTH-1:0]  r_readdata;
    logic                  w_wr_mask;
    logic                  w_wr_edge;
    logic                  w_unused_wdata;

    pong_pio_sync #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (in_port),
        .o_q   (w_sync_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_q <= '0;
        end else begin
            r_prev_q <= w_sync_q;
        end
    end

    // NOTE: the default is assigned first so no path through the case leaves
    // w_edge unassigned, which would otherwise infer a latch.
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  w_edge = w_sync_q & ~r_prev_q;
            EDGE_FALLING: w_edge = ~w_sync_q & r_prev_q;
            default:      w_edge = w_sync_q ^ r_prev_q;
        endcase
    end

    assign w_wr_mask = bus.write && (bus.address == ADDR_MASK);
    assign w_wr_edge = bus.write && (bus.address == ADDR_EDGE);
    assign w_clear   = w_wr_edge ? bus.writedata[DATA_WIDTH-1:0] : '0;

    // Clear is applied before the OR so a coincident new edge keeps its bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_capture <= '0;
            r_irq_mask     <= '0;
        end else begin
            r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge;
            if (w_wr_mask) begin
                r_irq_mask <= bus.writedata[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_rd_nxt = '0;
        case (addr_e'(bus.address))
            ADDR_DATA: w_rd_nxt[DATA_WIDTH-1:0] = w_sync_q;
            ADDR_MASK: w_rd_nxt[DATA_WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE: w_rd_nxt[DATA_WIDTH-1:0] = r_edge_capture;
            default:   w_rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_nxt;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edge_capture & r_irq_mask);

    // Upper write-data bits carry no meaning for narrow ports.
    assign w_unused_wdata = &{1'b0, bus.writedata};

endmodule

// File: tb/tb_pong_pio_edge_in.sv
// Self-checking bench: four pong_pio_edge_in instances (rising, falling, any,
// and a 4-bit/3-stage rising port) on a shared bus, checked against a model.
module tb_pong_pio_edge_in;
    import pong_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        wr = 1'b0;
    logic [31:0] wd = 32'd0;
    logic [7:0]  in_val = 8'd0;

    always #5 clk = ~clk;

    pong_pio_edge_in_if bus0 ();
    pong_pio_edge_in_if bus1 ();
    pong_pio_edge_in_if bus2 ();
    pong_pio_edge_in_if bus3 ();

    assign bus0.address = addr;  assign bus0.write = wr;  assign bus0.writedata = wd;
    assign bus1.address = addr;  assign bus1.write = wr;  assign bus1.writedata = wd;
    assign bus2.address = addr;  assign bus2.write = wr;  assign bus2.writedata = wd;
    assign bus3.address = addr;  assign bus3.write = wr;  assign bus3.writedata = wd;

    logic [31:0] rd_obs  [4];
    logic        irq_obs [4];

    assign rd_obs[0] = bus0.readdata;
    assign rd_obs[1] = bus1.readdata;
    assign rd_obs[2] = bus2.readdata;
    assign rd_obs[3] = bus3.readdata;

    pong_pio_edge_in #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .in_port(in_val), .irq(irq_obs[0]));
    pong_pio_edge_in #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_FALLING)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .in_port(in_val), .irq(irq_obs[1]));
    pong_pio_edge_in #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .in_port(in_val), .irq(irq_obs[2]));
    pong_pio_edge_in #(.DATA_WIDTH(4), .SYNC_STAGES(3), .EDGE_TYPE(EDGE_RISING)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .in_port(in_val[3:0]), .irq(irq_obs[3]));

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a history of sampled inputs stands in for the
    // synchronizer; registers are tracked per instance as plain values.
    logic [7:0]  hist [$];
    logic [31:0] m_cap  [4];
    logic [31:0] m_mask [4];
    logic [31:0] m_rd   [4];
    logic        m_irq  [4];

    function automatic int wid(int k);
        return (k == 3) ? 4 : 8;
    endfunction

    function automatic int stg(int k);
        return (k == 3) ? 3 : 2;
    endfunction

    function automatic int etype(int k);
        case (k)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] wmask(int k);
        return 32'((64'd1 << wid(k)) - 64'd1);
    endfunction

    // Input value sampled 'age' clock edges ago (0 = this edge); zero before reset release.
    function automatic logic [31:0] smp(int age);
        if (age < hist.size()) return {24'd0, hist[hist.size() - 1 - age]};
        return 32'd0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 4; k++) begin
            m_cap[k] = '0; m_mask[k] = '0; m_rd[k] = '0; m_irq[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] s, p, e, clr;
        hist.push_back(in_val);
        if (hist.size() > 8) void'(hist.pop_front());
        for (int k = 0; k < 4; k++) begin
            s = smp(stg(k)) & wmask(k);
            p = smp(stg(k) + 1) & wmask(k);
            case (addr)
                2'd0:    m_rd[k] = s;
                2'd1:    m_rd[k] = 32'd0;
                2'd2:    m_rd[k] = m_mask[k];
                default: m_rd[k] = m_cap[k];
            endcase
            case (etype(k))
                0:       e = s & ~p;
                1:       e = ~s & p;
                default: e = s ^ p;
            endcase
            e = e & wmask(k);
            clr = (wr && addr == 2'd3) ? (wd & wmask(k)) : 32'd0;
            m_cap[k] = (m_cap[k] & ~clr) | e;
            if (wr && addr == 2'd2) m_mask[k] = wd & wmask(k);
            m_irq[k] = |(m_cap[k] & m_mask[k]);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rd%0d", k), rd_obs[k], m_rd[k]);
            check($sformatf("irq%0d", k), {31'd0, irq_obs[k]}, {31'd0, m_irq[k]});
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_rd%0d", tag, k), rd_obs[k], 32'd0);
            check($sformatf("%s_irq%0d", tag, k), {31'd0, irq_obs[k]}, 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        wr = 1'b0;
        repeat (n) step();
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        addr = a; wr = 1'b1; wd = d;
        step();
        wr = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Data read latency; input already high at release is captured as rising.
        addr = 2'd0; in_val = 8'hA5;
        idle(3);
        check("data_a5", rd_obs[0], 32'h0000_00A5);
        addr = 2'd3;
        idle(1);
        check("cap_after_reset", rd_obs[0], 32'h0000_00A5);

        // Rising capture on bit0 with mask, then write-1-to-clear.
        in_val = 8'hA4;
        idle(4);
        write_reg(2'd3, 32'hFF);
        write_reg(2'd2, 32'h01);
        in_val = 8'hA5;
        idle(3);
        check("rise_irq_set", {31'd0, irq_obs[0]}, 32'd1);
        addr = 2'd3;
        idle(1);
        check("rise_cap", rd_obs[0], 32'h01);
        write_reg(2'd3, 32'h01);
        check("rise_irq_clr", {31'd0, irq_obs[0]}, 32'd0);
        idle(1);
        check("rise_cap_clr", rd_obs[0], 32'h00);

        // Falling capture on bit3 with mask off, then unmask.
        write_reg(2'd2, 32'h00);
        write_reg(2'd3, 32'hFF);
        in_val = 8'hAD;
        idle(4);
        write_reg(2'd3, 32'hFF);
        in_val = 8'hA5;
        idle(3);
        check("fall_irq_masked", {31'd0, irq_obs[1]}, 32'd0);
        addr = 2'd3;
        idle(1);
        check("fall_cap", rd_obs[1], 32'h08);
        write_reg(2'd2, 32'h08);
        check("fall_irq_unmask", {31'd0, irq_obs[1]}, 32'd1);

        // Any-edge on bit7 coinciding with a clear of bit7: set wins.
        in_val = 8'h25;
        idle(4);
        write_reg(2'd3, 32'hFF);
        in_val = 8'hA5;
        idle(2);
        write_reg(2'd3, 32'h80);
        idle(1);
        check("any_set_wins", rd_obs[2], 32'h80);

        // Narrow port: mask truncated to DATA_WIDTH, reserved address reads 0.
        write_reg(2'd2, 32'hFFFF_FFFF);
        addr = 2'd2;
        idle(1);
        check("narrow_mask", rd_obs[3], 32'h0000_000F);
        check("wide_mask", rd_obs[0], 32'h0000_00FF);
        addr = 2'd1;
        idle(1);
        check("narrow_rsvd", rd_obs[3], 32'h0);

        // Randomized traffic: all addresses, writes to every register, input changes.
        for (int i = 0; i < 400; i++) begin
            addr = 2'($urandom_range(0, 3));
            wr   = ($urandom_range(0, 2) == 0);
            wd   = $urandom;
            if ($urandom_range(0, 3) == 0) in_val = 8'($urandom);
            step();
        end
        wr = 1'b0;

        // Pending capture with irq high, then asynchronous reset mid-cycle.
        write_reg(2'd2, 32'hFF);
        write_reg(2'd3, 32'hFF);
        in_val = ~in_val;
        idle(4);
        check("pre_reset_irq", {31'd0, irq_obs[2]}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        addr = 2'd3;
        idle(1);
        check("post_reset_cap", rd_obs[2], 32'h0);
        addr = 2'd2;
        idle(1);
        check("post_reset_mask", rd_obs[2], 32'h0);
        addr = 2'd3;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
